mem_access: RTL and testbench

//  Memory-stage data-memory initiator: issues load/store requests over a req/ack bus; produces data for writeback.

---
 rtl/mem_pkg.sv | 44 ++++
 rtl/m_lane_align.sv | 29 ++
 rtl/mem_access.sv | 122 ++++++++++++
 tb/tb_mem_access.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-access stage.
// Size and state encodings plus byte-enable / alignment rules.
package mem_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic [3:0] be_gen(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic [3:0] be;
    be = 4'b1111;
    unique case (1'b1)
      size == SZ_BYTE: be = 4'b0001 << off;
      size == SZ_HALF: be = 4'b0011 << {off[1], 1'b0};
      default:         be = 4'b1111;
    endcase
    return be;
  endfunction

  // Size 2'b11 decodes as a word, so it shares the word rule.
  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic m;
    m = 1'b0;
    unique case (1'b1)
      size == SZ_BYTE: m = 1'b0;
      size == SZ_HALF: m = off[0];
      default:         m = |off;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/m_lane_align.sv
// Byte-lane steering between the core and the 32-bit data bus.
// Store data replication / enables and load right-justification.
module m_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  st_off,
  input  logic [31:0] wdata,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_rj
);

  always_comb begin
    be        = be_gen(size, st_off);
    wdata_rep = wdata;
    unique case (1'b1)
      size == SZ_BYTE: wdata_rep = {4{wdata[7:0]}};
      size == SZ_HALF: wdata_rep = {2{wdata[15:0]}};
      default:         wdata_rep = wdata;
    endcase
  end

  // Upper bits are left for writeback to extend or discard.
  assign rdata_rj = rdata >> {ld_off, 3'b000};

endmodule

// File: rtl/mem_access.sv
// M-stage data-memory initiator: req/ack bus master with
// stall, misalignment rejection and bus timeout.
module mem_access #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 7
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_con_Mmemread,
  input  logic        i_con_Mmemwrite,
  input  logic [1:0]  i_con_Msize,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_data_wdata,
  output logic        o_con_stall,
  output logic [31:0] o_data_memout,
  output logic        o_con_memvalid,
  output logic        o_con_misalign,
  output logic        o_con_timeout,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);
  import mem_pkg::*;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYC - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       cap_off;
  logic             op;
  logic             mis;
  logic [3:0]       be_s;
  logic [31:0]      wdata_s;
  logic [31:0]      rdata_rj;

  assign op  = i_con_Mmemread | i_con_Mmemwrite;
  assign mis = misaligned(i_con_Msize, i_data_addr[1:0]);

  m_lane_align u_lane (
    .size      (i_con_Msize),
    .st_off    (i_data_addr[1:0]),
    .wdata     (i_data_wdata),
    .ld_off    (cap_off),
    .rdata     (i_mem_rdata),
    .be        (be_s),
    .wdata_rep (wdata_s),
    .rdata_rj  (rdata_rj)
  );

  always_comb begin
    o_con_stall    = 1'b0;
    o_con_misalign = 1'b0;
    if (state == ST_BUSY) begin
      o_con_stall = 1'b1;
    end else if (state == ST_IDLE && op) begin
      o_con_stall    = ~mis;
      o_con_misalign = mis;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      cap_off        <= 2'b00;
      o_data_memout  <= '0;
      o_con_memvalid <= 1'b0;
      o_con_timeout  <= 1'b0;
      o_mem_req      <= 1'b0;
      o_mem_we       <= 1'b0;
      o_mem_addr     <= '0;
      o_mem_be       <= '0;
      o_mem_wdata    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (op && !mis) begin
            state       <= ST_BUSY;
            cnt         <= '0;
            cap_off     <= i_data_addr[1:0];
            o_mem_req   <= 1'b1;
            o_mem_we    <= i_con_Mmemwrite;
            o_mem_addr  <= {i_data_addr[31:2], 2'b00};
            o_mem_be    <= be_s;
            o_mem_wdata <= wdata_s;
          end
        end
        ST_BUSY: begin
          cnt <= cnt + CNT_W'(1);
          // An ack on the final cycle still counts as success.
          if (i_mem_ack || cnt == CNT_LAST) begin
            state          <= ST_DONE;
            o_con_memvalid <= 1'b1;
            o_con_timeout  <= ~i_mem_ack;
            o_mem_req      <= 1'b0;
            o_mem_we       <= 1'b0;
            o_mem_addr     <= '0;
            o_mem_be       <= '0;
            o_mem_wdata    <= '0;
            if (!i_mem_ack)
              o_data_memout <= '0;
            else if (!o_mem_we)
              o_data_memout <= rdata_rj;
          end
        end
        ST_DONE: begin
          state          <= ST_IDLE;
          cnt            <= '0;
          o_con_memvalid <= 1'b0;
          o_con_timeout  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed + random bench for mem_access against a
// transaction-level model of the bus and lane rules.
module tb_mem_access;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd, wr;
  logic [1:0]  sz;
  logic [31:0] addr, wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        stall, memvalid, misalign, tout;
  logic        req, we;
  logic [31:0] memout, maddr, mwdata;
  logic [3:0]  be;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_memout = '0;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT_CYC(TO), .CNT_W(7)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_con_Mmemread  (rd),
    .i_con_Mmemwrite (wr),
    .i_con_Msize     (sz),
    .i_data_addr     (addr),
    .i_data_wdata    (wdata),
    .o_con_stall     (stall),
    .o_data_memout   (memout),
    .o_con_memvalid  (memvalid),
    .o_con_misalign  (misalign),
    .o_con_timeout   (tout),
    .o_mem_req       (req),
    .o_mem_we        (we),
    .o_mem_addr      (maddr),
    .o_mem_be        (be),
    .o_mem_wdata     (mwdata),
    .i_mem_ack       (ack),
    .i_mem_rdata     (rdata)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, " stall"}, 32'(stall), 0);
    chk({tag, " req"}, 32'(req), 0);
    chk({tag, " we"}, 32'(we), 0);
    chk({tag, " addr"}, maddr, 0);
    chk({tag, " be"}, 32'(be), 0);
    chk({tag, " wdata"}, mwdata, 0);
    chk({tag, " valid"}, 32'(memvalid), 0);
    chk({tag, " tout"}, 32'(tout), 0);
    chk({tag, " misal"}, 32'(misalign), 0);
    chk({tag, " memout"}, memout, exp_memout);
  endtask

  // ack_at: BUSY cycle (1-based) carrying ack; 0 = never.
  task automatic run_op(input string tag,
                        input logic r, input logic w,
                        input logic [1:0] s,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input int ack_at,
                        input logic [31:0] rdd);
    int unsigned off, eb, nstall, exp_stall;
    logic [31:0] ew;
    logic half, byt, mis, acked;
    off  = a % 4;
    half = (s == 2'd1);
    byt  = (s == 2'd2);
    mis  = half ? (off % 2 != 0)
                : (!byt && off != 0);
    if (byt) begin
      eb = 1 << off;
      ew = (wd & 32'hff) * 32'h01010101;
    end else if (half) begin
      eb = 3 << (off & 2);
      ew = (wd & 32'hffff) * 32'h00010001;
    end else begin
      eb = 15;
      ew = wd;
    end
    acked = (ack_at >= 1 && ack_at <= TO);
    exp_stall = 1 + (acked ? ack_at : TO);

    @(negedge clk);
    rd = r; wr = w; sz = s; addr = a; wdata = wd;
    ack = 1'b0; rdata = rdd;
    #1;
    if (mis) begin
      chk({tag, " misal"}, 32'(misalign), 1);
      chk({tag, " mis stall"}, 32'(stall), 0);
      chk({tag, " mis req"}, 32'(req), 0);
      @(negedge clk);
      rd = 0; wr = 0;
      #1;
      chk({tag, " mis req2"}, 32'(req), 0);
      chk({tag, " mis memout"}, memout, exp_memout);
      return;
    end
    chk({tag, " idle stall"}, 32'(stall), 1);
    chk({tag, " idle req"}, 32'(req), 0);
    nstall = 1;
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      ack   = (ack_at == k);
      rdata = rdd;
      addr  = $urandom;
      wdata = $urandom;
      #1;
      chk({tag, " req"}, 32'(req), 1);
      chk({tag, " we"}, 32'(we), 32'(w));
      chk({tag, " maddr"}, maddr, a & ~32'h3);
      chk({tag, " be"}, 32'(be), eb);
      if (w) chk({tag, " mwdata"}, mwdata, ew);
      if (stall) nstall++;
      if (ack_at == k) break;
    end
    if (!w || !acked)
      exp_memout = acked ? (rdd >> (8 * off)) : 32'h0;
    @(negedge clk);
    ack = 1'b0;
    rdata = $urandom;
    #1;
    if (stall) nstall++;
    chk({tag, " nstall"}, nstall, exp_stall);
    chk({tag, " valid"}, 32'(memvalid), 1);
    chk({tag, " tout"}, 32'(tout), 32'(!acked));
    chk({tag, " memout"}, memout, exp_memout);
    chk({tag, " done req"}, 32'(req), 0);
    @(negedge clk);
    rd = 0; wr = 0;
    ack = 1'b1;
    #1;
    chk({tag, " idle valid"}, 32'(memvalid), 0);
    chk({tag, " idle req2"}, 32'(req), 0);
    @(negedge clk);
    ack = 1'b0;
    #1;
    chk({tag, " late ack"}, 32'(req), 0);
    chk({tag, " hold memout"}, memout, exp_memout);
  endtask

  initial begin
    rst_n = 1'b0;
    rd = 0; wr = 0; sz = 0; addr = 0; wdata = 0;
    ack = 0; rdata = 0;
    repeat (3) @(negedge clk);
    #1;
    all_zero("reset");
    rst_n = 1'b1;

    run_op("lw100", 1, 0, 2'd0, 32'h100, 0, 3,
           32'hDEADBEEF);
    run_op("lb103", 1, 0, 2'd2, 32'h103, 0, 1,
           32'hAABBCCDD);
    run_op("sh202", 0, 1, 2'd1, 32'h202, 32'h1234, 2,
           32'h0);
    run_op("lw101", 1, 0, 2'd0, 32'h101, 0, 1, 32'h0);
    run_op("to", 1, 0, 2'd0, 32'h40, 0, 0, 32'h55);
    run_op("ack4", 1, 0, 2'd1, 32'h42, 0, 4,
           32'h87654321);
    run_op("sw11", 1, 1, 2'd3, 32'h84, 32'hCAFEF00D, 1,
           32'h0);

    for (int i = 0; i < 30; i++) begin
      logic r, w;
      r = 1'($urandom);
      w = 1'($urandom);
      if (!r && !w) r = 1'b1;
      run_op($sformatf("rnd%0d", i), r, w,
             2'($urandom), $urandom, $urandom,
             int'($urandom_range(0, 5)), $urandom);
    end

    // Reset while a load is waiting on the bus.
    @(negedge clk);
    rd = 1; sz = 0; addr = 32'h300;
    repeat (3) @(negedge clk);
    #1;
    chk("rst busy req", 32'(req), 1);
    rst_n = 1'b0;
    rd = 0;
    #1;
    exp_memout = '0;
    all_zero("rst async");
    @(negedge clk);
    rst_n = 1'b1;
    ack = 1'b1; rdata = 32'h12345678;
    #1;
    all_zero("rst ack");
    @(negedge clk);
    ack = 1'b0;
    #1;
    all_zero("rst after");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
